// File: rtl/pc_pkg.sv
// Shared action encoding and default sizing for the program-counter block.
package pc_pkg;

  // One action is selected per cycle by the priority decoder.
  typedef enum logic [2:0] {
    PC_HOLD,
    PC_JMP,
    PC_CALL,
    PC_RET,
    PC_INC
  } pc_act_e;

  localparam int DEF_INSTR_ADDR_SIZE = 5;
  localparam int DEF_STACK_DEPTH     = 4;

endpackage

// File: rtl/call_stack.sv
// Return-address LIFO: saturating pointer, top-of-stack read combinationally.
module call_stack #(
  parameter int DATA_W = 5,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty
);
  import pc_pkg::*;

  localparam int PW    = $clog2(DEPTH + 1);
  // Storage is rounded up to a power of two so any pointer value indexes legally.
  localparam int SLOTS = 1 << PW;

  logic [PW-1:0]     ptr_q, ptr_d;
  logic [PW-1:0]     top_idx;
  logic [DATA_W-1:0] entries_q [SLOTS];

  assign full    = (ptr_q == PW'(DEPTH));
  assign empty   = (ptr_q == '0);
  assign top_idx = ptr_q - PW'(1);
  assign dout    = entries_q[top_idx];

  // Next pointer: push/pop are ignored when they would leave the 0..DEPTH range.
  always_comb begin
    ptr_d = ptr_q;
    if (push && !full) begin
      ptr_d = ptr_q + PW'(1);
    end else if (pop && !empty) begin
      ptr_d = ptr_q - PW'(1);
    end
  end

  // Pointer register; only control state is reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  // Entry storage is data only and keeps its contents across reset.
  always_ff @(posedge clk) begin
    if (push && !full) begin
      entries_q[ptr_q] <= din;
    end
  end

endmodule

// File: rtl/pc_stack.sv
// Program counter with call/return stack, priority decode and sticky error flags.
module pc_stack
  import pc_pkg::*;
#(
  parameter int INSTR_ADDR_SIZE = DEF_INSTR_ADDR_SIZE,
  parameter int STACK_DEPTH     = DEF_STACK_DEPTH
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       STALL,
  input  logic                       JMP,
  input  logic                       CALL,
  input  logic                       RET,
  input  logic                       CLR_ERR,
  input  logic [INSTR_ADDR_SIZE-1:0] JMP_ADDR,
  output logic [INSTR_ADDR_SIZE-1:0] INSTR_ADDR,
  output logic                       STACK_FULL,
  output logic                       STACK_EMPTY,
  output logic                       OVERFLOW,
  output logic                       UNDERFLOW
);

  localparam int W = INSTR_ADDR_SIZE;

  pc_act_e      act;
  logic [W-1:0] pc_q, pc_d;
  logic [W-1:0] pc_plus1;
  logic [W-1:0] ret_addr;
  logic         ovf_q, ovf_d;
  logic         unf_q, unf_d;
  logic         push, pop;
  logic         full, empty;

  assign pc_plus1 = pc_q + W'(1);

  call_stack #(
    .DATA_W (W),
    .DEPTH  (STACK_DEPTH)
  ) u_call_stack (
    .clk   (CLK),
    .rst   (RST),
    .push  (push),
    .pop   (pop),
    .din   (pc_plus1),
    .dout  (ret_addr),
    .full  (full),
    .empty (empty)
  );

  // Priority decode (STALL > JMP > CALL > RET > increment) and next PC / flags.
  always_comb begin
    act   = PC_INC;
    pc_d  = pc_plus1;
    push  = 1'b0;
    pop   = 1'b0;
    ovf_d = ovf_q & ~CLR_ERR;
    unf_d = unf_q & ~CLR_ERR;

    if (STALL)     act = PC_HOLD;
    else if (JMP)  act = PC_JMP;
    else if (CALL) act = PC_CALL;
    else if (RET)  act = PC_RET;

    unique case (act)
      PC_HOLD: pc_d = pc_q;
      PC_JMP:  pc_d = JMP_ADDR;
      PC_CALL: begin
        if (full) begin
          ovf_d = 1'b1;
        end else begin
          push = 1'b1;
          pc_d = JMP_ADDR;
        end
      end
      PC_RET: begin
        if (empty) begin
          unf_d = 1'b1;
        end else begin
          pop  = 1'b1;
          pc_d = ret_addr;
        end
      end
      default: pc_d = pc_plus1;
    endcase
  end

  // PC and sticky flag registers; reset overrides every other input.
  always_ff @(posedge CLK) begin
    if (RST) begin
      pc_q  <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign INSTR_ADDR  = pc_q;
  assign STACK_FULL  = full;
  assign STACK_EMPTY = empty;
  assign OVERFLOW    = ovf_q;
  assign UNDERFLOW   = unf_q;

endmodule

// File: doc/pc_stack.md
PC_STACK -- requirements
Module: pc_stack

Interface
REQ-001 SHALL have parameter INSTR_ADDR_SIZE, default 5, meaning the instruction address width in bits.
REQ-002 SHALL have parameter STACK_DEPTH, default 4, meaning the number of return-address entries (>=1).
REQ-003 CLK  input  1  system clock; all state changes on posedge CLK.
REQ-004 RST  input  1  synchronous, active-high reset.
REQ-005 STALL  input  1  hold PC and stack unchanged this cycle.
REQ-006 JMP  input  1  unconditional jump to JMP_ADDR.
REQ-007 CALL  input  1  push return address and jump to JMP_ADDR.
REQ-008 RET  input  1  pop return address into PC.
REQ-009 CLR_ERR  input  1  clear sticky error flags.
REQ-010 JMP_ADDR  input  INSTR_ADDR_SIZE  jump/call target.
REQ-011 INSTR_ADDR  output  INSTR_ADDR_SIZE  current instruction address (registered).
REQ-012 STACK_FULL  output  1  occupancy == STACK_DEPTH (combinational from pointer).
REQ-013 STACK_EMPTY  output  1  occupancy == 0 (combinational from pointer).
REQ-014 OVERFLOW  output  1  sticky: CALL attempted while full.
REQ-015 UNDERFLOW  output  1  sticky: RET attempted while empty.

Function
REQ-016 Per-cycle priority SHALL be RST > STALL > JMP > CALL > RET > increment; only the highest active action takes effect.
REQ-017 Increment SHALL be INSTR_ADDR+1 modulo 2^INSTR_ADDR_SIZE (all-ones wraps to 0, no flag).
REQ-018 JMP SHALL load JMP_ADDR next cycle; stack untouched.
REQ-019 CALL when not full SHALL push (INSTR_ADDR+1) mod 2^INSTR_ADDR_SIZE, increment occupancy, load JMP_ADDR next cycle.
REQ-020 CALL when full SHALL leave stack unchanged, not jump, increment PC, set OVERFLOW.
REQ-021 RET when not empty SHALL load the top entry into INSTR_ADDR next cycle and decrement occupancy.
REQ-022 RET when empty SHALL leave stack unchanged, increment PC, set UNDERFLOW.
REQ-023 STALL SHALL freeze INSTR_ADDR, stack contents and occupancy; OVERFLOW/UNDERFLOW are not set while stalled.
REQ-024 CLR_ERR SHALL clear both sticky flags next cycle unless the same cycle sets one, in which case the set wins.
REQ-025 Latency from any control input to INSTR_ADDR change SHALL be exactly one cycle; no combinational path from inputs to INSTR_ADDR.
REQ-026 Stack pointer SHALL be $clog2(STACK_DEPTH+1) bits and never exceed STACK_DEPTH or go below 0.

Reset
REQ-027 On RST: INSTR_ADDR=0, occupancy=0 (STACK_EMPTY=1, STACK_FULL=0), OVERFLOW=0, UNDERFLOW=0.
REQ-028 RST SHALL override all other inputs in the same cycle, including mid-call/return sequences; stack entry contents need not be cleared.

Structure
REQ-029 Shared package pc_pkg SHALL hold the action-select enum (PC_HOLD, PC_JMP, PC_CALL, PC_RET, PC_INC) and default parameter constants.
REQ-030 The LIFO SHALL be a separate sub-module call_stack (push, pop, data in/out, full, empty), parametrised by width and depth; pc_stack holds priority decode, PC register and flags.

Verification
REQ-031 RST then 3 idle cycles -> INSTR_ADDR 0,1,2,3; STACK_EMPTY=1.
REQ-032 PC=31, no controls -> next INSTR_ADDR=0, no flags.
REQ-033 PC=2, CALL JMP_ADDR=10; PC=11, CALL JMP_ADDR=20; RET; RET -> INSTR_ADDR 10,11,20,12,3.
REQ-034 Four CALLs fill stack (STACK_FULL=1); fifth CALL JMP_ADDR=7 at PC=p -> INSTR_ADDR=p+1, OVERFLOW=1, stays 1 until CLR_ERR.
REQ-035 RET with empty stack at PC=5 -> INSTR_ADDR=6, UNDERFLOW=1; JMP+CALL+STALL together -> PC and occupancy unchanged; JMP+CALL -> jump only, occupancy unchanged.
REQ-036 RST asserted the cycle after a CALL with occupancy 2 -> INSTR_ADDR=0, STACK_EMPTY=1, flags 0.
